// File: rtl/sng_stream_controller_if.sv
// ----------------------------------------------------------------------------
// sng_stream_controller_if
// Purpose : Request/result handshake bundle between a job source and
//           sng_stream_controller.
// Signals :
//   op_valid   source -> ctrl   operand triple valid
//   op_ready   ctrl   -> source controller can accept operands
//   x1,x2,x3   source -> ctrl   operands, WIDTH bits each
//   res_valid  ctrl   -> source result available
//   res_ready  source -> ctrl   consumer accepts result
//   res_count  ctrl   -> source number of ones counted, CW bits
// Modports: master (request source / result consumer), slave (controller).
// ----------------------------------------------------------------------------
interface sng_stream_controller_if #(
    parameter int WIDTH      = 4,
    parameter int STREAM_LEN = 15
);
    localparam int CW = $clog2(STREAM_LEN + 1);

    logic             op_valid;
    logic             op_ready;
    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] x2;
    logic [WIDTH-1:0] x3;
    logic             res_valid;
    logic             res_ready;
    logic [CW-1:0]    res_count;

    modport master (
        output op_valid, x1, x2, x3, res_ready,
        input  op_ready, res_valid, res_count
    );

    modport slave (
        input  op_valid, x1, x2, x3, res_ready,
        output op_ready, res_valid, res_count
    );
endinterface

// File: rtl/sng_stream_controller.sv
// ----------------------------------------------------------------------------
// sng_stream_controller
// Purpose : Sequences a single stochastic number generator (SNG) datapath.
//           Accepts an operand triple, holds the SNG in clear for one cycle,
//           waits out the SNG comparator pipeline (WARMUP cycles), then counts
//           ones on the SNG bitstream for STREAM_LEN cycles and presents the
//           count as a binary result. One job in flight at a time.
// Parameters:
//   WIDTH      operand width (SNG X inputs / LFSR state width)
//   STREAM_LEN bitstream cycles counted per job (>= 1)
//   WARMUP     cycles after SNG clear during which sng_sbs is ignored
// Ports:
//   clk, rst   clock; asynchronous active-high reset
//   bus        request/result handshake (sng_stream_controller_if.slave)
//   sng_clr    registered clear to the SNG reset input
//   sng_x1..3  held operands to the SNG
//   sng_sbs    SNG output bitstream
//   busy       controller is not idle
//   abort      cancel the job in flight (only with SNG_CTRL_ABORT_EN)
// Build option:
//   SNG_CTRL_ABORT_EN  adds the abort input; abort in CLEAR/WARM/RUN returns
//                      to IDLE with the count cleared and no result.
// ----------------------------------------------------------------------------
module sng_stream_controller #(
    parameter int WIDTH      = 4,
    parameter int STREAM_LEN = 15,
    parameter int WARMUP     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    sng_stream_controller_if.slave  bus,
    output logic                    sng_clr,
    output logic [WIDTH-1:0]        sng_x1,
    output logic [WIDTH-1:0]        sng_x2,
    output logic [WIDTH-1:0]        sng_x3,
    input  logic                    sng_sbs,
    output logic                    busy
`ifdef SNG_CTRL_ABORT_EN
    ,
    input  logic                    abort
`endif
);

    localparam int CW   = $clog2(STREAM_LEN + 1);
    localparam int CMAX = (WARMUP > STREAM_LEN) ? WARMUP : STREAM_LEN;
    localparam int CNTW = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CNTW-1:0] RUN_LAST  = CNTW'(STREAM_LEN - 1);
    localparam logic [CNTW-1:0] WARM_LAST = CNTW'((WARMUP > 0) ? WARMUP - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WARM,
        S_RUN,
        S_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]    res_count_q, res_count_d;
    logic [WIDTH-1:0] x1_q, x1_d;
    logic [WIDTH-1:0] x2_q, x2_d;
    logic [WIDTH-1:0] x3_q, x3_d;
    logic             clr_q, clr_d;
    logic             abort_req;

`ifdef SNG_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state and datapath decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        res_count_d = res_count_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        x3_d        = x3_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.op_valid) begin
                    x1_d        = bus.x1;
                    x2_d        = bus.x2;
                    x3_d        = bus.x3;
                    res_count_d = '0;
                    cnt_d       = '0;
                    state_d     = S_CLEAR;
                end
            end

            S_CLEAR: begin
                cnt_d   = '0;
                state_d = (WARMUP == 0) ? S_RUN : S_WARM;
            end

            S_WARM: begin
                if (cnt_q == WARM_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_RUN: begin
                res_count_d = res_count_q + CW'(sng_sbs);
                if (cnt_q == RUN_LAST) begin
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_HOLD: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides the normal sequencing while a job is in flight.
        if (abort_req && (state_q inside {S_CLEAR, S_WARM, S_RUN})) begin
            state_d     = S_IDLE;
            res_count_d = '0;
            cnt_d       = '0;
        end
    end

    // The SNG clear is decoded from the next state and registered so that
    // sng_clr is a clean flop output aligned with the state it belongs to.
    always_comb begin
        clr_d = (state_d == S_IDLE) || (state_d == S_CLEAR) || (state_d == S_HOLD);
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            res_count_q <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            x3_q        <= '0;
            clr_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            res_count_q <= res_count_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            x3_q        <= x3_d;
            clr_q       <= clr_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.op_ready  = (state_q == S_IDLE);
    assign bus.res_valid = (state_q == S_HOLD);
    assign bus.res_count = res_count_q;
    assign busy          = (state_q != S_IDLE);
    assign sng_clr       = clr_q;
    assign sng_x1        = x1_q;
    assign sng_x2        = x2_q;
    assign sng_x3        = x3_q;

endmodule

// File: tb/tb_sng_stream_controller.sv
// ----------------------------------------------------------------------------
// tb_sng_stream_controller
// Bench for sng_stream_controller with default parameters. A small SNG stub
// (4-bit XNOR LFSR cleared by sng_clr, 2-stage comparator pipeline) feeds the
// bitstream. Because a full 15-state LFSR period (states 0..14) is observed
// per job, the expected count is simply min(x1, x2, x3).
// ----------------------------------------------------------------------------
module tb_sng_stream_controller;

    localparam int WIDTH      = 4;
    localparam int STREAM_LEN = 15;
    localparam int WARMUP     = 2;
    localparam int CW         = $clog2(STREAM_LEN + 1);
    localparam int LAT        = 1 + WARMUP + STREAM_LEN + 1;  // accept edge -> first res_valid cycle

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sng_clr;
    logic [WIDTH-1:0] sng_x1, sng_x2, sng_x3;
    logic             sng_sbs;
    logic             busy;
`ifdef SNG_CTRL_ABORT_EN
    logic             abort = 1'b0;
`endif

    int passed = 0;
    int total  = 0;

    sng_stream_controller_if #(.WIDTH(WIDTH), .STREAM_LEN(STREAM_LEN)) bus ();

    sng_stream_controller #(
        .WIDTH(WIDTH),
        .STREAM_LEN(STREAM_LEN),
        .WARMUP(WARMUP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .sng_clr(sng_clr),
        .sng_x1(sng_x1),
        .sng_x2(sng_x2),
        .sng_x3(sng_x3),
        .sng_sbs(sng_sbs),
        .busy(busy)
`ifdef SNG_CTRL_ABORT_EN
        ,
        .abort(abort)
`endif
    );

    always #5 clk = ~clk;

    // SNG stub: LFSR and comparator pipeline, synchronously cleared.
    logic [3:0] lfsr;
    logic       s1, s2;
    always_ff @(posedge clk) begin
        if (sng_clr) begin
            lfsr <= '0;
            s1   <= 1'b0;
            s2   <= 1'b0;
        end else begin
            lfsr <= {lfsr[2:0], ~(lfsr[3] ^ lfsr[2])};
            s1   <= (lfsr < sng_x1) && (lfsr < sng_x2) && (lfsr < sng_x3);
            s2   <= s1;
        end
    end
    assign sng_sbs = s2;

    function automatic logic [CW-1:0] min3(input logic [3:0] a, b, c);
        logic [3:0] m;
        m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        return CW'(m);
    endfunction

    // Waits (bounded) for op_ready, presents operands, lets the accept edge pass.
    task automatic start_job(input logic [3:0] a, b, c, input logic rr, output bit ok);
        bit seen;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.op_ready === 1'b1) begin
                seen = 1;
                break;
            end
        end
        total++;
        if (!seen) begin
            $display("FAIL op_ready_wait: got op_ready=%b, required 1 within 50 cycles", bus.op_ready);
            ok = 0;
            return;
        end
        passed++;
        bus.op_valid  = 1'b1;
        bus.x1        = a;
        bus.x2        = b;
        bus.x3        = c;
        bus.res_ready = rr;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        bus.x1       = 4'($urandom);
        bus.x2       = 4'($urandom);
        bus.x3       = 4'($urandom);
        ok = 1;
    endtask

    // Full job: latency, sng_clr window, operand hold, count, optional backpressure.
    task automatic do_job(input logic [3:0] a, b, c, input int hold_wait, input bit poke);
        bit ok, clr_ok, x_ok, st_ok;
        int lat;
        logic [CW-1:0] exp_cnt;
        exp_cnt = min3(a, b, c);
        start_job(a, b, c, (hold_wait == 0), ok);
        if (!ok) return;
        lat = 0; clr_ok = 1; x_ok = 1;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (sng_x1 !== a || sng_x2 !== b || sng_x3 !== c) x_ok = 0;
            if (bus.res_valid === 1'b1) begin
                lat = j;
                break;
            end
            if (sng_clr !== ((j >= 2 && j <= LAT - 1) ? 1'b0 : 1'b1)) clr_ok = 0;
        end
        total++;
        if (lat != LAT) $display("FAIL res_valid_latency: got %0d, required %0d", lat, LAT);
        else passed++;
        if (lat == 0) return;
        total++;
        if (!clr_ok) $display("FAIL sng_clr_window: got mismatch pattern, required low only cycles 2..%0d", LAT - 1);
        else passed++;
        total++;
        if (!x_ok) $display("FAIL sng_x_held: got %0d/%0d/%0d, required %0d/%0d/%0d", sng_x1, sng_x2, sng_x3, a, b, c);
        else passed++;
        total++;
        if (bus.res_count !== exp_cnt) $display("FAIL res_count x=%0d,%0d,%0d: got %0d, required %0d", a, b, c, bus.res_count, exp_cnt);
        else passed++;
        total++;
        if (sng_clr !== 1'b1) $display("FAIL sng_clr_hold: got %b, required 1", sng_clr);
        else passed++;
        if (hold_wait > 0) begin
            st_ok = 1;
            if (poke) begin
                bus.op_valid = 1'b1;
                bus.x1 = 4'd3; bus.x2 = 4'd15; bus.x3 = 4'd15;
            end
            for (int h = 0; h < hold_wait; h++) begin
                @(negedge clk);
                if (bus.res_valid !== 1'b1 || bus.res_count !== exp_cnt || bus.op_ready !== 1'b0 ||
                    sng_x1 !== a || sng_x2 !== b || sng_x3 !== c || busy !== 1'b1) st_ok = 0;
            end
            total++;
            if (!st_ok) $display("FAIL hold_stable: got valid=%b count=%0d ready=%b x1=%0d, required 1/%0d/0/%0d",
                                 bus.res_valid, bus.res_count, bus.op_ready, sng_x1, exp_cnt, a);
            else passed++;
            bus.op_valid  = 1'b0;
            bus.res_ready = 1'b1;
        end
        @(negedge clk);
        total++;
        if (bus.res_valid !== 1'b0 || bus.op_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL return_idle: got valid=%b ready=%b busy=%b, required 0/1/0", bus.res_valid, bus.op_ready, busy);
        else passed++;
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (bus.op_ready !== 1'b1 || busy !== 1'b0 || bus.res_valid !== 1'b0)
            $display("FAIL reset_ctrl: got ready=%b busy=%b valid=%b, required 1/0/0", bus.op_ready, busy, bus.res_valid);
        else passed++;
        total++;
        if (sng_clr !== 1'b1) $display("FAIL reset_clr: got %b, required 1", sng_clr);
        else passed++;
        total++;
        if (bus.res_count !== '0 || sng_x1 !== '0 || sng_x2 !== '0 || sng_x3 !== '0)
            $display("FAIL reset_data: got count=%0d x=%0d/%0d/%0d, required 0", bus.res_count, sng_x1, sng_x2, sng_x3);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_job(4'd15, 4'd15, 4'd15, 0, 0);
        do_job(4'd8,  4'd15, 4'd15, 0, 0);
        do_job(4'd0,  4'd15, 4'd15, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            do_job(4'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(0, 3)), 0);
        end
    endtask

    task automatic test_backpressure();
        do_job(4'd12, 4'd15, 4'd13, 10, 1);
        do_job(4'd3, 4'd15, 4'd15, 0, 0);
    endtask

    task automatic test_reset_midrun();
        bit ok;
        start_job(4'd15, 4'd15, 4'd15, 1'b1, ok);
        if (!ok) return;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.op_ready !== 1'b1 || sng_clr !== 1'b1 ||
            bus.res_count !== '0 || sng_x1 !== '0)
            $display("FAIL midrun_reset: got busy=%b valid=%b ready=%b clr=%b count=%0d x1=%0d, required 0/0/1/1/0/0",
                     busy, bus.res_valid, bus.op_ready, sng_clr, bus.res_count, sng_x1);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        do_job(4'd9, 4'd11, 4'd14, 0, 0);
    endtask

    task automatic test_abort();
`ifdef SNG_CTRL_ABORT_EN
        bit ok, seen_valid;
        start_job(4'd15, 4'd15, 4'd15, 1'b1, ok);
        if (!ok) return;
        repeat (6) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++;
        if (bus.op_ready !== 1'b1 || busy !== 1'b0 || bus.res_valid !== 1'b0 || sng_clr !== 1'b1 || bus.res_count !== '0)
            $display("FAIL abort_idle: got ready=%b busy=%b valid=%b clr=%b count=%0d, required 1/0/0/1/0",
                     bus.op_ready, busy, bus.res_valid, sng_clr, bus.res_count);
        else passed++;
        seen_valid = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) seen_valid = 1;
        end
        total++;
        if (seen_valid) $display("FAIL abort_no_result: got res_valid=1, required 0");
        else passed++;
        bus.res_ready = 1'b0;
        do_job(4'd5, 4'd15, 4'd7, 0, 0);
`else
        do_job(4'd15, 4'd15, 4'd15, 0, 0);
`endif
    endtask

    initial begin
        bus.op_valid  = 1'b0;
        bus.res_ready = 1'b0;
        bus.x1 = '0; bus.x2 = '0; bus.x3 = '0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midrun();
        test_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sng_stream_controller.md
Name: sng_stream_controller

Overview:
- Sequences one stochastic number generator (SNG) datapath: accepts an operand triple, clears the SNG, and waits out the SNG comparator pipeline.
- Counts ones on the SNG output bitstream over a fixed stream length and returns the count as a binary result.
- Sits between a request source (valid/ready) and a single SNG instance; one job in flight at a time.

Parameters:
- WIDTH, 4, operand width; matches SNG X inputs and LFSR state width.
- STREAM_LEN, 15, SBS bits counted per job; must be >= 1 (15 = one full 4-bit LFSR period).
- WARMUP, 2, cycles after SNG clear during which SBS is ignored; covers the 2-stage comparator delay; 0 skips WARM.
- CW (localparam), $clog2(STREAM_LEN+1), result width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- op_valid  in  1  operand triple valid
- op_ready  out  1  controller can accept operands
- x1, x2, x3  in  WIDTH each  operands
- sng_clr  out  1  registered clear to SNG reset input
- sng_x1, sng_x2, sng_x3  out  WIDTH each  held operands to SNG
- sng_sbs  in  1  SNG output bitstream
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_count  out  CW  number of ones counted
- busy  out  1  state != IDLE
- abort  in  1  only with ABORT_EN

Behaviour:
- Reset: state=IDLE, sng_clr=1, sng_x*=0, res_valid=0, res_count=0, busy=0, internal counters 0. Reset mid-job discards it immediately; no partial result.
- States: IDLE, CLEAR, WARM, RUN, HOLD.
- IDLE: op_ready=1. On op_valid&op_ready at edge k: latch x1..x3 into sng_x*, zero res_count -> CLEAR.
- CLEAR: exactly 1 cycle -> WARM (-> RUN if WARMUP=0).
- WARM: WARMUP cycles; SBS ignored -> RUN.
- RUN: STREAM_LEN cycles; at each edge ending a RUN cycle res_count += sng_sbs. After last RUN cycle -> HOLD.
- HOLD: res_valid=1; res_count and sng_x* stable until res_valid&res_ready, then -> IDLE with res_valid=0. res_ready outside HOLD ignored.
- op_ready=1 only in IDLE; op_valid outside IDLE ignored; no back-to-back acceptance in HOLD.
- sng_clr is a flop loaded from next-state decode: 1 in IDLE, CLEAR, HOLD; 0 in WARM and RUN. Glitch-free.
- Timing (defaults): accept at edge k -> CLEAR cycle k+1, WARM k+2..k+3, RUN k+4..k+18, res_valid first high in cycle k+19.
- res_count cannot overflow: max STREAM_LEN fits CW.
- sng_x* change only on acceptance; stable from CLEAR through HOLD.

Optional Feature:
- Macro SNG_CTRL_ABORT_EN.
- Defined: abort input exists. abort=1 in CLEAR, WARM or RUN -> next state IDLE, res_count cleared, no res_valid pulse, sng_clr=1 next cycle. abort ignored in IDLE and HOLD.
- Undefined: no abort port; every accepted job runs to HOLD.

Test Plan:
- x1=x2=x3=15, accept at edge k, res_ready=1 -> res_valid in cycle k+19, res_count=15, sng_clr low exactly cycles k+2..k+18.
- x1=8, x2=x3=15 -> res_count=8 (LFSR visits 0..7 once per 15-state period); x1=0, x2=x3=15 -> res_count=0.
- Backpressure: res_ready=0 for 10 cycles in HOLD -> res_valid, res_count, sng_x* stable; op_valid=1 with x1=3 not accepted (op_ready=0); after res_ready=1, return to IDLE and accept next.
- Reset asserted mid-RUN (cycle k+10) -> outputs immediately at reset values, no res_valid; after release a new job completes with the correct count.
- SNG_CTRL_ABORT_EN: abort=1 in cycle k+6 -> IDLE in k+7, no res_valid, op_ready=1; without macro, same stimulus completes normally with res_count=15 for all-15 operands.
